ts_record_framer: RTL and testbench
===================================

# ts_record_framer

Consumes completed timestamp records (ID, start timestamp, end timestamp, delta) from the event timestamper's output handshake. Serializes them big-endian into a byte-wide AXI-Stream frame destined for the UDP payload builder. Each frame carries a header, 1..RECS_PER_FRAME records, and a trailer with record count and XOR checksum. A partially filled frame is closed after an idle timeout.

## Interface
- ID_W, 4, record ID width; legal range 1..8.
- TS_W, 64, timestamp width; must be a multiple of 8.
- RECS_PER_FRAME, 4, maximum records per frame; legal range 1..255.
- FLUSH_TIMEOUT, 1024, number of idle cycles in WAIT before a partial frame is closed; minimum 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rec_valid  in  1  record offered.
- rec_ready  out  1  record accepted when high together with rec_valid.
- rec_id  in  ID_W  event ID.
- rec_start_ts  in  TS_W  start timestamp.
- rec_end_ts  in  TS_W  end timestamp.
- rec_delta  in  TS_W  end minus start.
- m_tdata  out  8  stream byte.
- m_tvalid  out  1  byte valid.
- m_tready  in  1  downstream accepts byte.
- m_tlast  out  1  last byte of frame.

## Operation
- One-entry holding register (HOLD) for the incoming record.
  - rec_ready = !hold_full; rec_ready is 0 while rst is high.
  - A record loads into HOLD on rec_valid && rec_ready.
  - HOLD is freed when the last byte of that record is handshaken.
- Record layout, RB = 1 + 3*TS_W/8 bytes (25 at defaults):
  - id zero-extended to 8 bits, then start_ts, then end_ts, then delta.
  - Every field is MSB byte first.
- Frame layout: 0xA5 (magic), seq, records, count, chk.
  - count = number of records in the frame.
  - chk = XOR of every preceding byte in the frame, including magic and count.
  - m_tlast is asserted only on chk.
- seq: 8-bit frame counter, reset 0, incremented after chk is handshaken, wraps 255 -> 0.
- State machine:
  - IDLE: go to HDR when hold_full.
  - HDR: emit magic, then seq. Go to REC.
  - REC: emit RB bytes from HOLD. After the last byte, rec_cnt++. Then:
    - rec_cnt == RECS_PER_FRAME -> TRL;
    - otherwise, if a new record is held -> REC;
    - otherwise -> WAIT.
  - WAIT: timeout counter starts at 0 on entry and increments each cycle.
    - hold_full -> REC. A held record wins over a timeout expiring in the same cycle.
    - Counter == FLUSH_TIMEOUT-1 with no held record -> TRL.
  - TRL: emit count, then chk. After chk, go to HDR if hold_full, else IDLE. Clear rec_cnt and the checksum accumulator.
- Byte index and state advance only on m_tvalid && m_tready.
  - m_tvalid is 1 in HDR, REC and TRL; 0 in IDLE and WAIT.

## Timing
- Reset values:
  - m_tvalid = 0, m_tlast = 0, m_tdata = 0x00;
  - state IDLE, seq 0, rec_cnt 0, hold empty, checksum 0.
  - rec_ready rises the first cycle after rst deasserts.
- Latency: a record accepted at cycle N when in IDLE gives m_tvalid = 1 with magic at cycle N+2.
- AXI-Stream rule: once m_tvalid is high, m_tdata, m_tlast and m_tvalid stay stable until m_tready. m_tdata is a mux of registered state only.
- Backpressure: m_tready = 0 stalls all counters except the WAIT timeout, which runs only in WAIT.
- HOLD refills during any state once freed. Back-to-back records cost one idle cycle on m_tvalid, because rec_ready is not bypassed from m_tready.
- rst mid-frame: the frame is abandoned with no tlast and all state returns to reset values. A consumer treats a truncated frame as a dropped packet.

## Structure
- Package ts_pkg holds:
  - FRAME_MAGIC = 8'hA5;
  - function rec_bytes(TS_W);
  - the state enum {IDLE, HDR, REC, WAIT, TRL}.
- Single module, no sub-module. Holding register, byte-index counter ($clog2(RB)), timeout counter and checksum accumulator are inline.

## Test plan
- One record, then idle: id=3, start=0x10, end=0x15, delta=5.
  - Frame: A5 00 03 00×7 10 00×7 15 00×7 05 01 A7.
  - tlast on A7; timeout fires after 1024 WAIT cycles.
- Four back-to-back records (RECS_PER_FRAME=4):
  - frame closes without waiting for the timeout; count = 04; the next frame has seq = 01.
- Random m_tready = 0 stalls during a frame:
  - byte sequence identical to the unstalled run;
  - tdata/tlast held stable while tvalid = 1 and tready = 0.
- Record arrives on the cycle the WAIT counter equals FLUSH_TIMEOUT-1:
  - record joins the current frame; no trailer is emitted yet.
- 256 frames: seq wraps 0xFF -> 0x00, and chk is correct on both wrap frames.
- rst asserted mid-record:
  - next cycle tvalid = 0 and rec_ready = 0;
  - after release, the next frame starts with A5 00.

Source files
------------

// File: rtl/ts_pkg.sv
// Shared constants, state encoding and byte helpers for the timestamp record framer.
package ts_pkg;

  localparam logic [7:0] FRAME_MAGIC = 8'hA5;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    REC  = 3'd2,
    WAIT = 3'd3,
    TRL  = 3'd4
  } state_e;

  function automatic int rec_bytes(input int ts_w);
    return 1 + 3 * (ts_w / 8);
  endfunction

  function automatic logic [7:0] chk_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/ts_record_framer.sv
// Packs timestamp records big-endian into byte-wide AXI-Stream frames:
// magic, seq, 1..RECS_PER_FRAME records, count, XOR checksum (tlast on checksum).
module ts_record_framer
  import ts_pkg::*;
#(
  parameter int ID_W           = 4,
  parameter int TS_W           = 64,
  parameter int RECS_PER_FRAME = 4,
  parameter int FLUSH_TIMEOUT  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rec_valid,
  output logic            rec_ready,
  input  logic [ID_W-1:0] rec_id,
  input  logic [TS_W-1:0] rec_start_ts,
  input  logic [TS_W-1:0] rec_end_ts,
  input  logic [TS_W-1:0] rec_delta,
  output logic [7:0]      m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            m_tlast
);

  localparam int RB = rec_bytes(TS_W);
  localparam int RW = RB * 8;
  localparam int IW = $clog2(RB);
  localparam int TW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(RB - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(FLUSH_TIMEOUT - 1);
  localparam logic [7:0]    RECS_MAX = 8'(RECS_PER_FRAME);

  state_e        state_q, state_d;
  logic [RW-1:0] hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          rec_ready_q, rec_ready_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          tlast_q, tlast_d;

  logic          hs;
  logic          load;
  logic [7:0]    id8;
  logic [RW-1:0] rec_vec;

  assign hs        = tvalid_q && m_tready;
  assign load      = rec_valid && rec_ready_q;
  assign rec_ready = rec_ready_q;
  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tlast   = tlast_q;

  // Incoming record laid out in transmit order, first byte in the top bits.
  always_comb begin
    id8            = 8'h00;
    id8[ID_W-1:0]  = rec_id;
    rec_vec        = {id8, rec_start_ts, rec_end_ts, rec_delta};
  end

  // Next-state, counters, holding register and next stream outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    chk_d   = chk_q;

    if (load) begin
      hold_d      = rec_vec;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = HDR;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        if (hs) begin
          chk_d = chk_next(chk_q, tdata_q);
          if (idx_q == '0) begin
            idx_d = IW'(1);
          end else begin
            idx_d   = '0;
            state_d = REC;
          end
        end else begin
          state_d = HDR;
        end
      end
      REC: begin
        if (hs) begin
          chk_d = chk_next(chk_q, tdata_q);
          if (idx_q == IDX_LAST) begin
            // rec_ready is low while HOLD is full, so no load can race this free.
            idx_d       = '0;
            cnt_d       = cnt_q + 8'd1;
            hold_full_d = 1'b0;
            if (cnt_q + 8'd1 == RECS_MAX) begin
              state_d = TRL;
            end else begin
              state_d = WAIT;
              tmo_d   = '0;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          state_d = REC;
        end
      end
      WAIT: begin
        // A record landing this very cycle beats an expiring timeout.
        if (hold_full_q || load) begin
          state_d = REC;
          idx_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = TRL;
          idx_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      TRL: begin
        if (hs) begin
          if (idx_q == '0) begin
            chk_d = chk_next(chk_q, tdata_q);
            idx_d = IW'(1);
          end else begin
            idx_d   = '0;
            seq_d   = seq_q + 8'd1;
            cnt_d   = 8'd0;
            chk_d   = 8'd0;
            state_d = hold_full_q ? HDR : IDLE;
          end
        end else begin
          state_d = TRL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rec_ready_d = !hold_full_d;

    tvalid_d = 1'b0;
    tlast_d  = 1'b0;
    tdata_d  = 8'h00;
    case (state_d)
      HDR: begin
        tvalid_d = 1'b1;
        if (idx_d == '0) begin
          tdata_d = FRAME_MAGIC;
        end else begin
          tdata_d = seq_d;
        end
      end
      REC: begin
        tvalid_d = 1'b1;
        tdata_d  = 8'(hold_d >> ((RB - 1 - int'(idx_d)) * 8));
      end
      TRL: begin
        tvalid_d = 1'b1;
        if (idx_d == '0) begin
          tdata_d = cnt_d;
        end else begin
          tdata_d = chk_d;
          tlast_d = 1'b1;
        end
      end
      default: begin
        tvalid_d = 1'b0;
      end
    endcase
  end

  // Register every piece of state and the stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rec_ready_q <= 1'b0;
      idx_q       <= '0;
      tmo_q       <= '0;
      seq_q       <= 8'd0;
      cnt_q       <= 8'd0;
      chk_q       <= 8'd0;
      tdata_q     <= 8'h00;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rec_ready_q <= rec_ready_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      seq_q       <= seq_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
    end
  end

endmodule

// File: tb/tb_ts_record_framer.sv
// Scoreboard bench for ts_record_framer: a frame-level model queues expected bytes,
// a monitor pops and compares them on every stream handshake.
module tb_ts_record_framer;

  localparam int ID_W = 4;
  localparam int TS_W = 64;
  localparam int RPF  = 4;
  localparam int FT   = 1024;
  localparam int RB   = 1 + 3 * (TS_W / 8);

  typedef struct {
    logic [7:0]  id;
    logic [63:0] s;
    logic [63:0] e;
    logic [63:0] d;
  } rec_t;

  logic            clk;
  logic            rst;
  logic            rec_valid;
  logic            rec_ready;
  logic [ID_W-1:0] rec_id;
  logic [TS_W-1:0] rec_start_ts;
  logic [TS_W-1:0] rec_end_ts;
  logic [TS_W-1:0] rec_delta;
  logic [7:0]      m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         hs_count = 0;
  int         model_seq = 0;
  int         hs_cyc[$];
  logic [8:0] exp_q[$];
  rec_t       grp[$];
  logic       stall_en = 1'b0;

  ts_record_framer #(
    .ID_W(ID_W), .TS_W(TS_W), .RECS_PER_FRAME(RPF), .FLUSH_TIMEOUT(FT)
  ) dut (
    .clk(clk), .rst(rst),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
    .rec_start_ts(rec_start_ts), .rec_end_ts(rec_end_ts), .rec_delta(rec_delta),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] v, input int k);
    return 8'(v >> (8 * k));
  endfunction

  function automatic rec_t rand_rec();
    rec_t r;
    r.id = 8'($urandom_range(0, 15));
    r.s  = {$urandom, $urandom};
    r.d  = {$urandom, $urandom};
    r.e  = r.s + r.d;
    return r;
  endfunction

  // Expected frame for the records in grp, built straight from the byte layout.
  task automatic push_frame();
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(8'hA5);
    b.push_back(8'(model_seq));
    foreach (grp[i]) begin
      b.push_back(grp[i].id);
      for (int k = TS_W / 8 - 1; k >= 0; k--) b.push_back(byte_of(grp[i].s, k));
      for (int k = TS_W / 8 - 1; k >= 0; k--) b.push_back(byte_of(grp[i].e, k));
      for (int k = TS_W / 8 - 1; k >= 0; k--) b.push_back(byte_of(grp[i].d, k));
    end
    b.push_back(8'(grp.size()));
    x = 8'h00;
    foreach (b[i]) x = x ^ b[i];
    foreach (b[i]) exp_q.push_back({1'b0, b[i]});
    exp_q.push_back({1'b1, x});
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic send(input rec_t r, output int acc);
    int g = 0;
    @(negedge clk);
    rec_valid    = 1'b1;
    rec_id       = r.id[ID_W-1:0];
    rec_start_ts = r.s;
    rec_end_ts   = r.e;
    rec_delta    = r.d;
    while (!rec_ready && g < 4000) begin
      @(negedge clk);
      g++;
    end
    acc = cyc;
    check("rec_accept", rec_ready, 1'b1);
    @(posedge clk);
    #1;
    rec_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int g = 0;
    while (hs_count < target && g < 4000) begin
      @(posedge clk);
      g++;
    end
    check("wait_bytes", hs_count >= target, 1'b1);
  endtask

  task automatic wait_drain(input int bound);
    int g = 0;
    while (exp_q.size() != 0 && g < bound) begin
      @(posedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: scoreboard pops on handshakes, plus AXI-Stream hold-stability.
  initial begin
    logic       pv, pr, pl;
    logic [7:0] pd;
    logic [8:0] e;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) check("stall_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, pl, pd});
        if (m_tvalid && m_tready) begin
          hs_cyc.push_back(cyc);
          hs_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {m_tlast, m_tdata}, 9'h1FF);
          end else begin
            e = exp_q.pop_front();
            check("stream_byte", {m_tlast, m_tdata}, e);
          end
        end
        pv = m_tvalid; pr = m_tready; pl = m_tlast; pd = m_tdata;
      end
    end
  end

  initial begin
    rec_t r, r2;
    int   acc, base, base0;
    rst = 1'b1; rec_valid = 1'b0; rec_id = '0;
    rec_start_ts = '0; rec_end_ts = '0; rec_delta = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 1'b0);
    check("rst_tlast", m_tlast, 1'b0);
    check("rst_tdata", m_tdata, 8'h00);
    check("rst_ready", rec_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_release_cycle", rec_ready, 1'b0);
    @(negedge clk);
    check("ready_after_release", rec_ready, 1'b1);

    // Single record, closed by the idle timeout.
    r.id = 8'h03; r.s = 64'h10; r.e = 64'h15; r.d = 64'h5;
    grp.delete(); grp.push_back(r); push_frame();
    base = hs_count;
    send(r, acc);
    @(negedge clk);
    check("latency_n1", m_tvalid, 1'b0);
    @(negedge clk);
    check("latency_n2", {m_tvalid, m_tdata}, {1'b1, 8'hA5});
    wait_drain(3000);
    check("timeout_gap", hs_cyc[base + RB + 2] - hs_cyc[base + RB + 1], FT + 1);

    // Two full frames of back-to-back records.
    base0 = hs_count;
    for (int g = 0; g < 2; g++) begin
      grp.delete();
      for (int i = 0; i < RPF; i++) grp.push_back(rand_rec());
      push_frame();
      for (int i = 0; i < RPF; i++) send(grp[i], acc);
    end
    wait_drain(3000);
    check("b2b_gap", hs_cyc[base0 + RB + 2] - hs_cyc[base0 + RB + 1], 2);
    check("full_no_timeout", hs_cyc[base0 + 2 + RPF * RB] - hs_cyc[base0 + 1 + RPF * RB], 1);

    // Second record offered exactly as the timeout counter reaches its last value.
    r = rand_rec(); r2 = rand_rec();
    grp.delete(); grp.push_back(r); grp.push_back(r2); push_frame();
    base = hs_count;
    send(r, acc);
    wait_hs(base + RB + 2);
    repeat (FT - 1) @(posedge clk);
    send(r2, acc);
    check("boundary_accept_cycle", acc - hs_cyc[base + RB + 1], FT);
    wait_drain(3000);

    // Random frames with stalls, long enough to wrap seq.
    stall_en = 1'b1;
    for (int f = 0; f < 260; f++) begin
      int n;
      n = ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, RPF - 1)) : RPF;
      grp.delete();
      for (int i = 0; i < n; i++) grp.push_back(rand_rec());
      push_frame();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send(grp[i], acc);
      end
      if (n < RPF) wait_drain(6000);
    end
    wait_drain(6000);
    stall_en = 1'b0;

    // Reset in the middle of a record abandons the frame.
    grp.delete(); grp.push_back(rand_rec()); push_frame();
    base = hs_count;
    send(grp[0], acc);
    wait_hs(base + 10);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    model_seq = 0;
    check("midrst_tvalid", m_tvalid, 1'b0);
    check("midrst_ready", rec_ready, 1'b0);
    check("midrst_tlast", m_tlast, 1'b0);
    check("midrst_tdata", m_tdata, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    grp.delete(); grp.push_back(rand_rec()); push_frame();
    send(grp[0], acc);
    wait_drain(3000);
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
